// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, 8 data bits LSB first, optional parity,
// one or two stop bits. tx, busy and done are registered.
module uart_tx #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       start,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   // done is registered, so it is raised one count before the last stop cycle
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic             PAR_EN    = (PARITY_EN != 0);
   localparam logic             PAR_ODD   = (PARITY_ODD != 0);

   // Elaboration-time parameter sanity checks
   if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic             stop_q, stop_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             par_q, par_d;
   logic             tx_d, busy_d, done_d;
   logic             bit_end_c;

   // Last clock of the current bit period
   assign bit_end_c = (baud_q == CNT_LAST);

   // Next-state, datapath and next-output logic
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      tx_d    = tx;
      busy_d  = busy;
      done_d  = 1'b0;

      if (state_q != IDLE) begin
         baud_d = bit_end_c ? '0 : CNT_W'(baud_q + 1'b1);
      end

      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            stop_d = 1'b0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (start) begin
               shreg_d = data_in;
               par_d   = (^data_in) ^ PAR_ODD;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end

         START: begin
            if (bit_end_c) begin
               state_d = DATA;
               tx_d    = shreg_q[0];
            end
         end

         DATA: begin
            if (bit_end_c) begin
               shreg_d = {1'b0, shreg_q[7:1]};
               bit_d   = 3'(bit_q + 3'd1);
               if (bit_q == 3'd7) begin
                  if (PAR_EN) begin
                     state_d = PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d = shreg_q[1];
               end
            end
         end

         PARITY: begin
            if (bit_end_c) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end

         STOP: begin
            tx_d = 1'b1;
            if ((baud_q == CNT_DONE) && (stop_q == STOP_LAST)) begin
               done_d = 1'b1;
            end
            if (bit_end_c) begin
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
                  stop_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            baud_d  = '0;
            bit_d   = '0;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset abandons any frame in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         tx      <= tx_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations driven in parallel,
// each checked every cycle against a frame-level reference model.
module tb_uart_tx;

   localparam int N = 10;  // 1 MHz / 100 kbaud
   localparam int PEN  [4] = '{1, 1, 0, 1};
   localparam int PODD [4] = '{0, 1, 0, 0};
   localparam int SB   [4] = '{1, 1, 1, 2};
   localparam int FLEN [4] = '{110, 110, 100, 120};

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] data_in;
   logic [3:0] tx_w, busy_w, done_w;

   int tests = 0;
   int fails = 0;
   int cyc_n = 0;
   int run_len [4];
   int last_len [4];
   int done_cnt [4];
   int last_done [4];
   int prev_done [4];
   logic [2:0] mq [4][$];   // expected {tx,busy,done} per future cycle

   always #5 clk = ~clk;

   uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .data_in(data_in), .start(start), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .data_in(data_in), .start(start), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .data_in(data_in), .start(start), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
   uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst(rst), .data_in(data_in), .start(start), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line bits in transmit order (bit 0 first); unused upper bits read as idle 1
   function automatic logic [11:0] frame_bits(input int k, input logic [7:0] d);
      logic [11:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      if (PEN[k] != 0) f[9] = (^d) ^ (PODD[k] != 0);
      return f;
   endfunction

   task automatic push_frame(input int k, input logic [7:0] d);
      logic [11:0] f;
      int total;
      f     = frame_bits(k, d);
      total = (9 + PEN[k] + SB[k]) * N;
      for (int c = 0; c < total; c++)
         mq[k].push_back({f[c / N], 1'b1, (c == total - 1)});
   endtask

   // Per-cycle compare against the model, plus busy-run and done bookkeeping
   always @(negedge clk) begin : cmp
      logic [2:0] exp;
      logic [2:0] act;
      cyc_n++;
      for (int k = 0; k < 4; k++) begin
         act = {tx_w[k], busy_w[k], done_w[k]};
         if (rst) begin
            mq[k].delete();
            exp = 3'b100;
         end else if (mq[k].size() > 0) begin
            exp = mq[k].pop_front();
         end else begin
            exp = 3'b100;
         end
         check($sformatf("cycle %0d inst %0d {tx,busy,done}", cyc_n, k), 32'(act), 32'(exp));
         if (!rst && !exp[1] && start) push_frame(k, data_in);
         if (busy_w[k]) run_len[k]++;
         else if (run_len[k] > 0) begin
            last_len[k] = run_len[k];
            run_len[k]  = 0;
         end
         if (done_w[k]) begin
            prev_done[k] = last_done[k];
            last_done[k] = cyc_n;
            done_cnt[k]++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d);
      data_in = d;
      start   = 1'b1;
      cyc(1);
      start   = 1'b0;
      data_in = 8'($urandom);
      check("busy one clock after accept", 32'(busy_w), 32'hF);
      check("start bit after accept", 32'(tx_w), 32'h0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_w != 4'h0 && n < 1000) begin
         cyc(1);
         n++;
      end
      check("wait idle within bound", 32'(busy_w), 32'h0);
      cyc(2);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int d0 [4];
      for (int k = 0; k < 4; k++) begin
         run_len[k] = 0; last_len[k] = 0; done_cnt[k] = 0;
         last_done[k] = 0; prev_done[k] = 0;
      end
      rst = 1'b1; start = 1'b0; data_in = 8'h00;
      cyc(3);
      check("reset tx", 32'(tx_w), 32'hF);
      check("reset busy", 32'(busy_w), 32'h0);
      check("reset done", 32'(done_w), 32'h0);
      rst = 1'b0;

      // Hand-derived frames pin the model
      check("model A5 even", 32'(frame_bits(0, 8'hA5)), 32'hD4A);
      check("model 07 odd", 32'(frame_bits(1, 8'h07)), 32'hC0E);
      check("model 07 no parity", 32'(frame_bits(2, 8'h07)), 32'hE0E);
      check("model 00 two stop", 32'(frame_bits(3, 8'h00)), 32'hC00);
      cyc(2);

      // Directed frames: busy length and single done per frame
      foreach (d0[k]) d0[k] = done_cnt[k];
      send(8'hA5);
      wait_idle();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("busy length A5 inst %0d", k), 32'(last_len[k]), 32'(FLEN[k]));
         check($sformatf("done count A5 inst %0d", k), 32'(done_cnt[k] - d0[k]), 32'd1);
      end
      send(8'h07);
      wait_idle();
      send(8'h00);
      wait_idle();
      for (int k = 0; k < 4; k++)
         check($sformatf("busy length 00 inst %0d", k), 32'(last_len[k]), 32'(FLEN[k]));

      // Start while busy is ignored
      foreach (d0[k]) d0[k] = done_cnt[k];
      send(8'hA5);
      cyc(40);
      data_in = 8'h3C;
      start   = 1'b1;
      cyc(1);
      start   = 1'b0;
      wait_idle();
      for (int k = 0; k < 4; k++)
         check($sformatf("done count busy-start inst %0d", k), 32'(done_cnt[k] - d0[k]), 32'd1);

      // Back-to-back with start held high
      foreach (d0[k]) d0[k] = done_cnt[k];
      data_in = 8'h55;
      start   = 1'b1;
      cyc(1);
      data_in = 8'hAA;
      cyc(149);
      start   = 1'b0;
      wait_idle();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("b2b done count inst %0d", k), 32'(done_cnt[k] - d0[k]), 32'd2);
         check($sformatf("b2b done spacing inst %0d", k), 32'(last_done[k] - prev_done[k]), 32'(FLEN[k] + 1));
      end

      // Asynchronous reset mid-frame
      send(8'hA5);
      cyc(34);
      #1 rst = 1'b1;
      #1;
      check("async reset tx", 32'(tx_w), 32'hF);
      check("async reset busy", 32'(busy_w), 32'h0);
      check("async reset done", 32'(done_w), 32'h0);
      cyc(3);
      rst = 1'b0;
      cyc(60);
      check("post-reset tx idle", 32'(tx_w), 32'hF);
      check("post-reset busy", 32'(busy_w), 32'h0);

      // Random start pulses and constantly changing data_in
      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom_range(0, 99) < 6);
         data_in = 8'($urandom);
         cyc(1);
      end
      start = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. It is the transmit-side counterpart of the existing receiver that produces data_RX, valid_RX and the frame, parity and overrun error flags.
- Accepts one byte per handshake from the control path: data_TX feeds data_in, and the FIFO read strobe gated with FIFO non-empty feeds start.
- Serialises each byte onto the tx line as start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Drives busy back to the control path, which uses it to throttle read_en.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, truncating). CLKS_PER_BIT must be at least 2; an elaboration-time error is raised otherwise.
- PARITY_EN, 1: 1 inserts a parity bit, 0 omits it.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- data_in  in  8  byte to send; sampled only on the accepting edge.
- start  in  1  request to send; accepted only when busy=0.
- tx  out  1  serial line, idles high.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse marking the end of the last stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - tx=1, busy=0, done=0.
  - State returns to IDLE; baud counter, bit counter and shift register are cleared.
  - A frame interrupted by reset is abandoned and never resumed.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance (IDLE with start=1):
  - data_in is latched into the shift register.
  - Parity is computed from the latched byte: XOR of the 8 bits, inverted if PARITY_ODD.
  - Next cycle: state=START, busy=1, tx=0.
  - Acceptance latency is 1 clock.
- start while busy=1 is ignored. No queuing, no error flag. data_in changes after acceptance have no effect.
- Bit timing:
  - The baud counter runs 0..CLKS_PER_BIT-1 inside each bit; tx is held constant for exactly CLKS_PER_BIT clocks per bit.
  - The state advances on the cycle the counter equals CLKS_PER_BIT-1. The counter then wraps to 0.
- START: lasts 1 bit time, then goes to DATA.
- DATA:
  - tx = shift register bit 0.
  - At each bit end the register shifts right and the 3-bit bit counter increments.
  - After bit index 7 the state goes to PARITY if PARITY_EN, else STOP.
- PARITY: tx = parity bit for 1 bit time, then STOP.
- STOP:
  - tx=1 for STOP_BITS bit times, tracked by a stop counter.
  - done=1 for exactly one clock, on the final cycle of the last stop bit, while busy is still 1.
  - Next cycle: IDLE, busy=0.
- Frame length in clocks: CLKS_PER_BIT*(10+PARITY_EN+STOP_BITS-1).
  - busy is high for exactly that many consecutive cycles.
- Back-to-back frames:
  - start held high is accepted on the first IDLE cycle.
  - Result: exactly 1 idle clock (tx=1) between frames.
- IDLE with start=0: tx=1 and all counters held at 0.
- Outputs tx, busy and done are registered, with no combinational path from inputs.

Test Plan:
- Reset mid-frame: CLK_FREQ=1_000_000, BAUD=100_000 (10 clk/bit), default parity and stop settings. Send 0xA5, assert rst during bit 3 -> tx=1 and busy=0 in the same cycle. After release, no further transitions on tx without a new start.
- Even parity, 0xA5: same parameters, start pulse with data_in=0xA5 -> busy rises 1 clock later.
  - tx sequence, 10 clocks per bit: 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1.
  - busy high for 110 cycles; done pulses on cycle 110.
- Odd parity, 0x07: PARITY_ODD=1, data_in=0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 0. With PARITY_EN=0 the parity slot is absent and the frame is 100 clocks.
- Two stop bits: STOP_BITS=2, byte 0x00 -> tx high for 20 clocks after the parity bit; frame is 120 clocks; done on the final clock.
- Start while busy: pulse start with 0x3C during the DATA phase of the 0xA5 frame -> frame unchanged, 0x3C never sent, exactly one done pulse.
- Back-to-back: start held high, data_in 0x55 then 0xAA -> second start bit begins exactly 1 clock after busy falls; both frames bit-exact; two done pulses 111 clocks apart.
